// File: rtl/bcd_freq_gen.sv
// BCD-programmed square-wave generator: D3.D2D1D0 Hz -> half period H = CLK_FREQ_HZ*500/F cycles.
// Optional o_half_period port enabled by defining BCD_FREQ_GEN_PERIOD_OUT_EN.
module bcd_freq_gen #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  localparam logic [63:0] DIV_NUM = 64'(CLK_FREQ_HZ) * 64'd500,
  localparam int DIV_W = $clog2(DIV_NUM + 64'd1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic [3:0]       i_freq_bcd [3:0],
  output logic             o_signal,
  output logic             o_busy,
  output logic             o_running,
`ifdef BCD_FREQ_GEN_PERIOD_OUT_EN
  output logic [DIV_W-1:0] o_half_period,
`endif
  output logic             o_err
);

  localparam int STEP_W = $clog2(DIV_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_CONV, S_DIV, S_RUN, S_ERR} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_dig [3:0];
  logic [13:0]       r_f;
  logic              r_bad;
  logic [STEP_W-1:0] r_step;
  logic [13:0]       r_rem;
  logic [DIV_W-1:0]  r_quo;
  logic [DIV_W-1:0]  r_h;
  logic [DIV_W-1:0]  r_cnt;
  logic              r_signal;

  logic [1:0]        w_idx;
  logic [3:0]        w_digit;
  logic [13:0]       w_f_next;
  logic              w_last_conv;
  logic              w_conv_bad;
  logic [14:0]       w_trial;
  logic              w_ge;
  logic [13:0]       w_rem_sub;
  logic              w_div_done;
  logic              w_toggle;

  // CONV walks the digits MSD first: step 0 reads index 3.
  assign w_idx       = 2'(2'd3 - r_step[1:0]);
  assign w_digit     = r_dig[w_idx];
  assign w_f_next    = r_f * 14'd10 + {10'd0, w_digit};
  assign w_last_conv = (r_step == STEP_W'(3));
  assign w_conv_bad  = r_bad || (w_digit > 4'd9) || (w_f_next == 14'd0);

  // Remainder is always below F, so the subtraction fits in 14 bits.
  assign w_trial    = {r_rem, r_quo[DIV_W-1]};
  assign w_ge       = (w_trial >= {1'b0, r_f});
  assign w_rem_sub  = w_trial[13:0] - r_f;
  assign w_div_done = (r_step == STEP_W'(DIV_W));
  assign w_toggle   = (r_cnt == r_h - DIV_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_start) begin
      w_next = S_CONV;
    end else begin
      case (r_state)
        S_CONV: begin
          if (i_stop)           w_next = S_IDLE;
          else if (w_last_conv) w_next = w_conv_bad ? S_ERR : S_DIV;
        end
        S_DIV: begin
          if (i_stop)          w_next = S_IDLE;
          else if (w_div_done) w_next = S_RUN;
        end
        S_RUN: begin
          if (i_stop) w_next = S_IDLE;
        end
        default: w_next = r_state;
      endcase
    end
  end

  // Outputs decode from state so an async reset clears them at once.
  always_comb begin
    o_busy    = (r_state == S_CONV) || (r_state == S_DIV);
    o_running = (r_state == S_RUN);
    o_err     = (r_state == S_ERR);
    o_signal  = (r_state == S_RUN) && r_signal;
  end

`ifdef BCD_FREQ_GEN_PERIOD_OUT_EN
  assign o_half_period = (r_state == S_RUN) ? r_h : '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dig    <= '{default: 4'd0};
      r_f      <= '0;
      r_bad    <= 1'b0;
      r_step   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_h      <= '0;
      r_cnt    <= '0;
      r_signal <= 1'b0;
    end else if (i_start) begin
      r_dig    <= i_freq_bcd;
      r_f      <= '0;
      r_bad    <= 1'b0;
      r_step   <= '0;
      r_cnt    <= '0;
      r_signal <= 1'b0;
    end else begin
      case (r_state)
        S_CONV: begin
          r_f    <= w_f_next;
          r_bad  <= r_bad || (w_digit > 4'd9);
          r_step <= r_step + STEP_W'(1);
          if (w_last_conv) begin
            r_step <= '0;
            r_rem  <= '0;
            r_quo  <= DIV_W'(DIV_NUM);
          end
        end
        S_DIV: begin
          if (!w_div_done) begin
            r_rem  <= w_ge ? w_rem_sub : w_trial[13:0];
            r_quo  <= {r_quo[DIV_W-2:0], w_ge};
            r_step <= r_step + STEP_W'(1);
          end else begin
            r_h      <= r_quo;
            r_cnt    <= '0;
            r_signal <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_toggle) begin
            r_cnt    <= '0;
            r_signal <= ~r_signal;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        default: r_signal <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_freq_gen.sv
// Directed bench for bcd_freq_gen at CLK_FREQ_HZ=1000 (DIV_W=19, start-to-rise latency 24 edges).
module tb_bcd_freq_gen;

  localparam int DIV_W = 19;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] freq_bcd [3:0];
  logic       sig;
  logic       busy;
  logic       running;
  logic       err;
`ifdef BCD_FREQ_GEN_PERIOD_OUT_EN
  logic [DIV_W-1:0] half_period;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bcd_freq_gen #(.CLK_FREQ_HZ(1000)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_freq_bcd   (freq_bcd),
    .o_signal     (sig),
    .o_busy       (busy),
    .o_running    (running),
`ifdef BCD_FREQ_GEN_PERIOD_OUT_EN
    .o_half_period(half_period),
`endif
    .o_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the digits with a one-cycle start pulse; returns 1 time unit after the sampling edge.
  task automatic start_req(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                           input logic [3:0] d0, input logic with_stop);
    freq_bcd[3] = d3;
    freq_bcd[2] = d2;
    freq_bcd[1] = d1;
    freq_bcd[0] = d0;
    start = 1'b1;
    stop  = with_stop;
    step();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic half_len(output int n);
    logic prev;
    prev = sig;
    n = 0;
    do begin
      step();
      n++;
    end while (sig === prev && n < 2000);
  endtask

  // Checks busy through edges 1..23 with o_signal low, then the rise at edge 24.
  task automatic check_rise(input string tag);
    int bad;
    bad = 0;
    for (int k = 1; k <= 23; k++) begin
      step();
      if (busy !== 1'b1 || sig !== 1'b0 || running !== 1'b0) bad++;
    end
    check({tag, "_busy_window"}, 64'(bad), 64'd0);
    step();
    check({tag, "_rise"}, {61'd0, sig, busy, running}, 64'b101);
  endtask

  initial begin
    int n;
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 4; i++) freq_bcd[i] = 4'd0;

    #22;
    check("reset_outputs", {60'd0, sig, busy, running, err}, 64'd0);
    rst_n = 1'b1;
    step();
    step();
    check("idle_outputs", {60'd0, sig, busy, running, err}, 64'd0);

    // 4.000 Hz: H = 500000/4000 = 125
    start_req(4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
    check("f4_busy_after_start", 64'(busy), 64'd1);
    check_rise("f4");
`ifdef BCD_FREQ_GEN_PERIOD_OUT_EN
    check("f4_half_period", 64'(half_period), 64'd125);
`endif
    bad = 0;
    for (int h = 0; h < 10; h++) begin
      half_len(n);
      if (n != 125) bad++;
    end
    check("f4_five_periods", 64'(bad), 64'd0);
    check("f4_still_running", 64'(running), 64'd1);

    // F = 0.001 Hz: H = 500000
    start_req(4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
    check_rise("f1");
`ifdef BCD_FREQ_GEN_PERIOD_OUT_EN
    check("f1_half_period", 64'(half_period), 64'd500000);
`endif
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (sig !== 1'b1) bad++;
    end
    check("f1_stays_high", 64'(bad), 64'd0);

    // F = 9.999 Hz: H = floor(500000/9999) = 50
    start_req(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
    check_rise("f9999");
`ifdef BCD_FREQ_GEN_PERIOD_OUT_EN
    check("f9999_half_period", 64'(half_period), 64'd50);
`endif
    half_len(n);
    check("f9999_high_len", 64'(n), 64'd50);
    half_len(n);
    check("f9999_low_len", 64'(n), 64'd50);

    // Zero frequency -> ERR after the 4 CONV cycles
    start_req(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < 4; k++) step();
    check("zero_err", {61'd0, err, busy, sig}, 64'b100);
    pulse_stop();
    check("err_ignores_stop", 64'(err), 64'd1);

    // Non-BCD digit -> ERR, signal never moves
    start_req(4'd0, 4'hA, 4'd0, 4'd0, 1'b0);
    check("bad_digit_err_cleared_by_start", 64'(err), 64'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sig !== 1'b0) bad++;
    end
    check("bad_digit_err", 64'(err), 64'd1);
    check("bad_digit_signal_low", 64'(bad), 64'd0);

    // Valid start clears error; then restart mid-RUN with 2.000 Hz
    start_req(4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
    check("valid_start_clears_err", 64'(err), 64'd0);
    check_rise("pre_restart");
    for (int k = 0; k < 10; k++) step();
    start_req(4'd2, 4'd0, 4'd0, 4'd0, 1'b0);
    check("restart_signal_low", {62'd0, sig, busy}, 64'b01);
    check_rise("f2");
    half_len(n);
    check("f2_high_len", 64'(n), 64'd250);
    half_len(n);
    check("f2_low_len", 64'(n), 64'd250);

    // Stop mid-DIV -> IDLE with no edge
    start_req(4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int k = 0; k < 10; k++) step();
    pulse_stop();
    check("stop_mid_div", {61'd0, sig, busy, running}, 64'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (sig !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("stop_quiet", 64'(bad), 64'd0);

    // Start and stop together: start wins
    start_req(4'd4, 4'd0, 4'd0, 4'd0, 1'b1);
    check("start_stop_busy", 64'(busy), 64'd1);
    check_rise("start_stop");
    for (int k = 0; k < 30; k++) step();

    // Async reset between edges during RUN
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {60'd0, sig, busy, running, err}, 64'd0);
    step();
    #4;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (sig !== 1'b0 || busy !== 1'b0 || running !== 1'b0) bad++;
    end
    check("post_reset_quiet", 64'(bad), 64'd0);
    start_req(4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
    check_rise("post_reset");
    half_len(n);
    check("post_reset_high_len", 64'(n), 64'd125);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
